// File: rtl/ahbtoapb3_apb_ctrl.sv
// rtl/ahbtoapb3_apb_ctrl.sv - AHB-Lite to APB3 bridge control FSM and datapath strobes
// Optional PREADY timeout abort enabled by defining AHBTOAPB3_PREADY_TIMEOUT_EN.
module ahbtoapb3_apb_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       HCLK,
  input  logic       HRESETN,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HWRITE,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  input  logic       PREADY,
  input  logic       PSLVERR,
  output logic       latchAddr,
  output logic       latchWrData,
  output logic       latchRdData,
  output logic       latchNextAddr,
  output logic       selNextAddr
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2, ST_LOADNXT
  } state_t;

  state_t state_q;
  logic   pwrite_q;
  logic   pend_write_q;
  logic   valid_xfer;

  assign valid_xfer = HSEL & HREADY & HTRANS[1];

  // Out-of-range configurations elaborate an empty marker block only.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_tmo_cfg_out_of_range
  end

`ifdef AHBTOAPB3_PREADY_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt_q;
`endif

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q      <= ST_IDLE;
      pwrite_q     <= 1'b0;
      pend_write_q <= 1'b0;
`ifdef AHBTOAPB3_PREADY_TIMEOUT_EN
      tmo_cnt_q    <= 16'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_xfer) begin
            pwrite_q <= HWRITE;
            state_q  <= HWRITE ? ST_WDATA : ST_SETUP;
          end
        end
        ST_WDATA: state_q <= ST_SETUP;
        ST_SETUP: begin
`ifdef AHBTOAPB3_PREADY_TIMEOUT_EN
          tmo_cnt_q <= 16'd0;
`endif
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state_q <= PSLVERR ? ST_ERR1 : ST_IDLE;
          end else begin
`ifdef AHBTOAPB3_PREADY_TIMEOUT_EN
            if (tmo_cnt_q + 16'd1 == TMO_LIMIT) begin
              state_q <= ST_ERR1;
            end
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
          end
        end
        ST_ERR1: state_q <= ST_ERR2;
        ST_ERR2: begin
          if (valid_xfer) begin
            pend_write_q <= HWRITE;
            pwrite_q     <= HWRITE;
            state_q      <= ST_LOADNXT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOADNXT: state_q <= ST_SETUP;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PWRITE    = pwrite_q;

  // Strobes are gated by reset so nothing loads while the bridge is held in reset.
  always_comb begin
    latchAddr     = 1'b0;
    latchWrData   = 1'b0;
    latchRdData   = 1'b0;
    latchNextAddr = 1'b0;
    selNextAddr   = 1'b0;
    if (HRESETN) begin
      case (state_q)
        ST_IDLE:    latchAddr     = valid_xfer;
        ST_WDATA:   latchWrData   = 1'b1;
        ST_ACCESS:  latchRdData   = PREADY & ~PSLVERR & ~pwrite_q;
        ST_ERR2:    latchNextAddr = valid_xfer;
        ST_LOADNXT: begin
          selNextAddr = 1'b1;
          latchWrData = pend_write_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbtoapb3_apb_ctrl.sv
// tb/tb_ahbtoapb3_apb_ctrl.sv - directed bench for the AHB-to-APB3 control FSM
module tb_ahbtoapb3_apb_ctrl;

  logic       HCLK = 1'b0;
  logic       HRESETN;
  logic       HSEL, HWRITE, HREADY, PREADY, PSLVERR;
  logic [1:0] HTRANS;
  logic       HREADYOUT, HRESP, PSEL, PENABLE, PWRITE;
  logic       latchAddr, latchWrData, latchRdData, latchNextAddr, selNextAddr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahbtoapb3_apb_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .latchAddr(latchAddr), .latchWrData(latchWrData),
    .latchRdData(latchRdData), .latchNextAddr(latchNextAddr),
    .selNextAddr(selNextAddr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic prdy, input logic perr);
    HSEL = sel; HTRANS = trans; HWRITE = wr; PREADY = prdy; PSLVERR = perr;
  endtask

  // Inputs change 1ns after the rising edge; checks follow at the falling edge.
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in(input logic prdy);
    drv(1'b0, 2'b00, 1'b0, prdy, 1'b0);
  endtask

  initial begin
    HRESETN = 1'b0;
    HREADY  = 1'b1;
    drv(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    #3;
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_latchaddr", latchAddr, 0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETN = 1'b1;

    // IDLE/BUSY transfers are ignored
    drv(1'b1, 2'b01, 1'b0, 1'b1, 1'b0); #4;
    chk("busy_latchaddr", latchAddr, 0);
    chk("busy_hreadyout", HREADYOUT, 1);
    next_cycle(); idle_in(1'b1); #4;
    chk("busy_psel", PSEL, 0);
    next_cycle();

    // Zero-wait read
    drv(1'b1, 2'b10, 1'b0, 1'b1, 1'b0); #4;
    chk("rd_c0_latchaddr", latchAddr, 1);
    chk("rd_c0_psel", PSEL, 0);
    next_cycle(); idle_in(1'b1); #4;
    chk("rd_c1_psel", PSEL, 1);
    chk("rd_c1_penable", PENABLE, 0);
    chk("rd_c1_hreadyout", HREADYOUT, 0);
    chk("rd_c1_latchaddr", latchAddr, 0);
    next_cycle(); #4;
    chk("rd_c2_psel", PSEL, 1);
    chk("rd_c2_penable", PENABLE, 1);
    chk("rd_c2_latchrd", latchRdData, 1);
    next_cycle();
    // Back-to-back: write accepted in the completion cycle
    drv(1'b1, 2'b10, 1'b1, 1'b0, 1'b0); #4;
    chk("rd_c3_hreadyout", HREADYOUT, 1);
    chk("rd_c3_hresp", HRESP, 0);
    chk("rd_c3_psel", PSEL, 0);
    chk("b2b_latchaddr", latchAddr, 1);
    next_cycle(); idle_in(1'b0); #4;
    chk("wr_c1_latchwr", latchWrData, 1);
    chk("wr_c1_hreadyout", HREADYOUT, 0);
    chk("wr_c1_pwrite", PWRITE, 1);
    chk("wr_c1_psel", PSEL, 0);
    next_cycle(); #4;
    chk("wr_c2_psel", PSEL, 1);
    chk("wr_c2_penable", PENABLE, 0);
    chk("wr_c2_latchwr", latchWrData, 0);
    next_cycle(); #4;
    chk("wr_c3_penable", PENABLE, 1);
    next_cycle(); #4;
    chk("wr_c4_penable", PENABLE, 1);
    chk("wr_c4_hreadyout", HREADYOUT, 0);
    next_cycle(); idle_in(1'b1); #4;
    chk("wr_c5_penable", PENABLE, 1);
    chk("wr_c5_latchrd", latchRdData, 0);
    chk("wr_c5_pwrite", PWRITE, 1);
    next_cycle(); #4;
    chk("wr_c6_hreadyout", HREADYOUT, 1);
    chk("wr_c6_psel", PSEL, 0);
    chk("wr_c6_pwrite_hold", PWRITE, 1);
    next_cycle();

    // Read with PSLVERR, no follow-on transfer
    drv(1'b1, 2'b10, 1'b0, 1'b1, 1'b1); #4;
    chk("er_c0_latchaddr", latchAddr, 1);
    next_cycle(); idle_in(1'b0); PSLVERR = 1'b1; #4;
    chk("er_c1_psel", PSEL, 1);
    next_cycle(); #4;
    chk("er_c2_ignored_perr_penable", PENABLE, 1);
    next_cycle(); PREADY = 1'b1; #4;
    chk("er_c3_latchrd", latchRdData, 0);
    chk("er_c3_penable", PENABLE, 1);
    next_cycle(); idle_in(1'b1); #4;
    chk("er_err1_hresp", HRESP, 1);
    chk("er_err1_hreadyout", HREADYOUT, 0);
    chk("er_err1_psel", PSEL, 0);
    next_cycle(); #4;
    chk("er_err2_hresp", HRESP, 1);
    chk("er_err2_hreadyout", HREADYOUT, 1);
    chk("er_err2_latchnext", latchNextAddr, 0);
    next_cycle(); #4;
    chk("er_idle_hresp", HRESP, 0);
    chk("er_idle_hreadyout", HREADYOUT, 1);
    next_cycle();

    // Read with PSLVERR, write pending in ERR2
    drv(1'b1, 2'b10, 1'b0, 1'b1, 1'b0); #4;
    next_cycle(); idle_in(1'b1); PSLVERR = 1'b1; #4;
    next_cycle(); #4;
    chk("en_access_latchrd", latchRdData, 0);
    next_cycle(); idle_in(1'b1); #4;
    chk("en_err1_hresp", HRESP, 1);
    next_cycle(); drv(1'b1, 2'b11, 1'b1, 1'b1, 1'b0); #4;
    chk("en_err2_latchnext", latchNextAddr, 1);
    chk("en_err2_latchaddr", latchAddr, 0);
    chk("en_err2_hreadyout", HREADYOUT, 1);
    next_cycle(); idle_in(1'b1); #4;
    chk("en_ld_selnext", selNextAddr, 1);
    chk("en_ld_latchwr", latchWrData, 1);
    chk("en_ld_hreadyout", HREADYOUT, 0);
    chk("en_ld_pwrite", PWRITE, 1);
    chk("en_ld_psel", PSEL, 0);
    next_cycle(); #4;
    chk("en_setup_psel", PSEL, 1);
    chk("en_setup_penable", PENABLE, 0);
    chk("en_setup_selnext", selNextAddr, 0);
    next_cycle(); #4;
    chk("en_access_penable", PENABLE, 1);
    chk("en_access_pwrite", PWRITE, 1);
    next_cycle(); #4;
    chk("en_done_hreadyout", HREADYOUT, 1);
    chk("en_done_hresp", HRESP, 0);
    next_cycle();

    // Asynchronous reset in ACCESS
    drv(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); #4;
    next_cycle(); idle_in(1'b0); #4;
    next_cycle(); #4;
    chk("rs_before_penable", PENABLE, 1);
    #1 HRESETN = 1'b0;
    #1;
    chk("rs_psel", PSEL, 0);
    chk("rs_penable", PENABLE, 0);
    chk("rs_hreadyout", HREADYOUT, 1);
    next_cycle();
    HRESETN = 1'b1;
    drv(1'b1, 2'b10, 1'b0, 1'b1, 1'b0); #4;
    chk("rs_new_latchaddr", latchAddr, 1);
    next_cycle(); idle_in(1'b1); #4;
    chk("rs_new_psel", PSEL, 1);
    chk("rs_new_pwrite", PWRITE, 0);
    next_cycle(); #4;
    chk("rs_new_latchrd", latchRdData, 1);
    next_cycle();

    // PREADY stuck low
    drv(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); #4;
    next_cycle(); idle_in(1'b0); #4;
    chk("to_setup_psel", PSEL, 1);
`ifdef AHBTOAPB3_PREADY_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #4;
      chk($sformatf("to_access%0d_penable", i), PENABLE, 1);
    end
    next_cycle(); #4;
    chk("to_err1_psel", PSEL, 0);
    chk("to_err1_hresp", HRESP, 1);
    chk("to_err1_hreadyout", HREADYOUT, 0);
    chk("to_err1_latchrd", latchRdData, 0);
    next_cycle(); #4;
    chk("to_err2_hresp", HRESP, 1);
    chk("to_err2_hreadyout", HREADYOUT, 1);
    next_cycle(); #4;
    chk("to_idle_hresp", HRESP, 0);
`else
    begin
      int not_access = 0;
      for (int i = 0; i < 1000; i++) begin
        next_cycle(); #4;
        if (PENABLE !== 1'b1 || PSEL !== 1'b1) not_access++;
      end
      chk("nto_cycles_left_access", not_access, 0);
      chk("nto_hreadyout", HREADYOUT, 0);
    end
    PREADY = 1'b1;
    next_cycle(); idle_in(1'b1); #4;
    chk("nto_done_hreadyout", HREADYOUT, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
